uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  Receive-side front end for the BT/WiFi UART links on GPIO_1: oversampling 8N1 deserialiser plus byte FIFO.
//  Sits between a raw RXD header pin and the NIOS system; presents received bytes on a valid/ready stream.
//  Also reports sticky framing/overrun status so firmware can detect lost data from the HC-05/ESP modules.
// PARAMETERS
//  CLK_HZ      50_000_000  system clock frequency (Hz)
//  BAUD        9600        line rate (bit/s)
//  OVERSAMPLE  16          sample ticks per bit; even, >=4
//  FIFO_DEPTH  16          byte entries; power of 2, >=2
// PORTS
//  clk        in   1                      system clock; all logic on rising edge
//  reset      in   1                      synchronous, active-high
//  rxd        in   1                      async serial input, idle high
//  out_data   out  8                      head-of-FIFO byte (show-ahead)
//  out_valid  out  1                      FIFO not empty
//  out_ready  in   1                      consumer pop; pop occurs when out_valid && out_ready
//  count      out  $clog2(FIFO_DEPTH+1)   bytes held
//  frame_err  out  1                      sticky: stop bit sampled low
//  overrun    out  1                      sticky: byte dropped, FIFO full
//  clear_err  in   1                      1-cycle pulse clears both sticky flags
// BEHAVIOUR
//  Reset: out_valid=0, count=0, out_data=0, frame_err=0, overrun=0; FSM IDLE; sync FFs=1; tick ctr=0.
//  Reset mid-frame aborts the frame; FIFO contents are discarded.
//  rxd passes a 2-FF synchroniser (rxs); all decisions use rxs (+2 cycles latency).
//  Tick: DIV = round(CLK_HZ/(BAUD*OVERSAMPLE)), min 1; 1-cycle tick every DIV clocks.
//   Tick ctr and sample ctr restart on the IDLE->START transition.
//  FSM:
//   IDLE:      rxs==0 -> START.
//   START:     at tick OVERSAMPLE/2: rxs==1 -> IDLE (glitch, nothing pushed); else DATA, bit=0.
//   DATA:      every OVERSAMPLE ticks sample rxs into shift reg, LSB first; after bit 7 -> STOP.
//   STOP:      after OVERSAMPLE ticks sample rxs:
//              1 -> push byte, IDLE.
//              0 -> frame_err<=1, byte discarded, WAIT_HIGH.
//   WAIT_HIGH: rxs==1 -> IDLE. Prevents a break/low line re-triggering START.
//  Push is a 1-cycle strobe in the stop-sample cycle.
//   out_valid rises next cycle if FIFO was empty; out_data is valid whenever out_valid=1.
//  Full: push with count==FIFO_DEPTH and no pop -> byte dropped, overrun<=1, contents unchanged.
//  Push+pop same cycle: both occur, count unchanged, byte accepted, no overrun, even when full.
//  Pop when empty (out_ready with out_valid=0): ignored.
//  Pointers wrap modulo FIFO_DEPTH; count tracks occupancy exactly (0..FIFO_DEPTH).
//  Byte order out == arrival order.
//  clear_err clears both flags.
//   A new error in the same cycle wins: flag stays 1.
// TESTING  (sim params CLK_HZ=1_600_000, BAUD=100_000, OVERSAMPLE=16 -> DIV=1, 16 clk/bit)
//  1. 8N1 frame 0xA5, out_ready=0 -> out_valid=1, out_data=0xA5, count=1, flags 0; pop -> count=0.
//  2. rxd low 5 clk then high -> no push, count=0, FSM back in IDLE; following 0x3C received correctly.
//  3. 0x3C frame with stop bit 0, line held low 40 clk -> frame_err=1, count=0.
//     Line high, then send 0x11 -> out_data=0x11.
//  4. 17 bytes 0x00..0x10 with out_ready=0, DEPTH=16 -> count=16, overrun=1.
//     Drain yields 0x00..0x0F in order; clear_err -> overrun=0.
//  5. reset pulse during DATA bit 4 of a frame -> next cycle out_valid=0, count=0, flags 0.
//     Next 0x7E frame received correctly.
//  6. FIFO full, out_ready=1 held in stop-sample cycle of byte 0x55 -> count stays 16, overrun=0.
//     0x55 appears last on drain.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   Receive front end for the GPIO_1 BT/WiFi UART links: a 2-FF input
//   synchroniser, an oversampling 8N1 deserialiser and a show-ahead byte
//   FIFO presented as a valid/ready stream, plus sticky framing and overrun
//   status for firmware.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   reset      synchronous, active-high
//   rxd        asynchronous serial input, idles high
//   out_data   head-of-FIFO byte (0 while the FIFO is empty)
//   out_valid  FIFO not empty
//   out_ready  consumer pop; a pop happens when out_valid && out_ready
//   count      number of bytes held (0..FIFO_DEPTH)
//   frame_err  sticky: a stop bit was sampled low
//   overrun    sticky: a byte arrived while the FIFO was full and was dropped
//   clear_err  one-cycle pulse clearing both sticky flags
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            rxd,
  output logic [7:0]                      out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
  output logic                            frame_err,
  output logic                            overrun,
  input  logic                            clear_err
);

  // Oversampling tick divider, rounded to nearest and never below 1.
  localparam int DIV_RAW = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [TW-1:0] DIV_LAST  = TW'(DIV - 1);
  localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t state, state_nxt;

  logic          rx_meta, rxs;
  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] samp_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          tick;

  // FSM strobes
  logic restart;     // IDLE->START: realign tick and sample counters
  logic samp_wrap;   // this tick ends a sample interval
  logic mid_tick;    // centre of the start bit
  logic bit_tick;    // centre of a data/stop bit
  logic push;        // good stop bit: byte in shift_reg is complete
  logic ferr_set;

  // FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, do_push, do_pop, ovr_set;

  // -------------------------------------------------------------------------
  // Input synchroniser; idles at 1 so reset never looks like a start bit.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make this a true two-stage shift;
      // blocking ones here would collapse both flops into a single stage.
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  assign tick = (tick_cnt == DIV_LAST);

  // -------------------------------------------------------------------------
  // Receive FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_nxt = state;
    restart   = 1'b0;
    push      = 1'b0;
    ferr_set  = 1'b0;
    mid_tick  = tick && (samp_cnt == HALF_LAST);
    bit_tick  = tick && (samp_cnt == BIT_LAST);
    samp_wrap = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rxs) begin
          state_nxt = START;
          restart   = 1'b1;
        end
      end
      START: begin
        samp_wrap = mid_tick;
        // Line back high at mid start bit is a glitch, not a frame.
        if (mid_tick) state_nxt = rxs ? IDLE : DATA;
      end
      DATA: begin
        samp_wrap = bit_tick;
        if (bit_tick && bit_cnt == 3'd7) state_nxt = STOP;
      end
      STOP: begin
        samp_wrap = bit_tick;
        if (bit_tick) begin
          if (rxs) begin
            push      = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_set  = 1'b1;
            state_nxt = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // Hold off until the line returns high so a break is one error,
        // not a stream of bogus frames.
        if (rxs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Bit timing and deserialiser
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt  <= '0;
      samp_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      if (restart) begin
        tick_cnt <= '0;
        samp_cnt <= '0;
      end else begin
        tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
        if (tick) samp_cnt <= samp_wrap ? '0 : samp_cnt + SW'(1);
      end
      if (state == START && mid_tick) bit_cnt <= '0;
      if (state == DATA && bit_tick) begin
        shift_reg <= {rxs, shift_reg[7:1]};  // LSB arrives first
        bit_cnt   <= bit_cnt + 3'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Byte FIFO. When full, a simultaneous pop frees the slot being written,
  // so push+pop is always accepted.
  // -------------------------------------------------------------------------
  assign full      = (count == DEPTH_C);
  assign out_valid = (count != '0);
  assign do_pop    = out_valid && out_ready;
  assign do_push   = push && (!full || do_pop);
  assign ovr_set   = push && full && !do_pop;
  assign out_data  = out_valid ? mem[rd_ptr] : 8'h00;

  // NOTE: the storage array has no reset; out_data is masked while empty,
  // so stale entries are never observable and the RAM maps cleanly.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shift_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky status: a new error in the clear cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (ferr_set)       frame_err <= 1'b1;
      else if (clear_err) frame_err <= 1'b0;
      if (ovr_set)        overrun   <= 1'b1;
      else if (clear_err) overrun   <= 1'b0;
    end
  end

endmodule
